// File: rtl/tug_of_war_field_if.sv
// Player-facing signal bundle for the tug-of-war playfield.
// The master side drives the key levels and restart; the slave side (the field) drives the displays.
interface tug_of_war_field_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  L;
  logic                  R;
  logic                  restart;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  win_left;
  logic                  win_right;
  logic [SCORE_W-1:0]    left_score;
  logic [SCORE_W-1:0]    right_score;
  logic                  match_over;

  modport master (
    output L, R, restart,
    input  lights, win_left, win_right, left_score, right_score, match_over
  );

  modport slave (
    input  L, R, restart,
    output lights, win_left, win_right, left_score, right_score, match_over
  );
endinterface

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: a single position register drives a one-hot LED bar.
// It detects key rising edges, round wins and per-player scores, and declares the match winner.
module tug_of_war_field #(
  parameter int NUM_LIGHTS   = 9,
  parameter int SCORE_W      = 3,
  parameter int MATCH_POINTS = 3,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tug_of_war_field_if.slave bus
);
  localparam int C     = (NUM_LIGHTS - 1) / 2;
  localparam int POS_W = $clog2(NUM_LIGHTS);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  state_t             state;
  logic [POS_W-1:0]   pos;
  logic [CNT_W-1:0]   cnt;
  logic               l_prev, r_prev;
  logic               press_l, press_r;
  logic [SCORE_W-1:0] l_sc, r_sc, l_sc_inc, r_sc_inc;
  logic               win_l, win_r, over;

  // The previous-key registers reset to 1, so a key held through reset is not seen as a press.
  assign press_l  = bus.L & ~l_prev;
  assign press_r  = bus.R & ~r_prev;
  assign l_sc_inc = l_sc + 1'b1;
  assign r_sc_inc = r_sc + 1'b1;

  // Main game FSM. Restart has the same effect as reset and takes priority over presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PLAY;
      pos    <= POS_W'(C);
      cnt    <= '0;
      l_prev <= 1'b1;
      r_prev <= 1'b1;
      l_sc   <= '0;
      r_sc   <= '0;
      win_l  <= 1'b0;
      win_r  <= 1'b0;
      over   <= 1'b0;
    end else begin
      l_prev <= bus.L;
      r_prev <= bus.R;
      if (bus.restart) begin
        state  <= PLAY;
        pos    <= POS_W'(C);
        cnt    <= '0;
        l_prev <= 1'b1;
        r_prev <= 1'b1;
        l_sc   <= '0;
        r_sc   <= '0;
        win_l  <= 1'b0;
        win_r  <= 1'b0;
        over   <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (press_l && !press_r) begin
              if (pos == POS_W'(NUM_LIGHTS - 1)) begin
                l_sc  <= l_sc_inc;
                win_l <= 1'b1;
                cnt   <= '0;
                if (l_sc_inc == SCORE_W'(MATCH_POINTS)) begin
                  state <= OVER;
                  over  <= 1'b1;
                end else begin
                  state <= HOLD;
                end
              end else begin
                pos <= pos + 1'b1;
              end
            end else if (press_r && !press_l) begin
              if (pos == '0) begin
                r_sc  <= r_sc_inc;
                win_r <= 1'b1;
                cnt   <= '0;
                if (r_sc_inc == SCORE_W'(MATCH_POINTS)) begin
                  state <= OVER;
                  over  <= 1'b1;
                end else begin
                  state <= HOLD;
                end
              end else begin
                pos <= pos - 1'b1;
              end
            end
          end
          // Win flag stays up for exactly HOLD_CYCLES cycles, then the light re-centres.
          HOLD: begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              state <= PLAY;
              pos   <= POS_W'(C);
              cnt   <= '0;
              win_l <= 1'b0;
              win_r <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          OVER:    ;
          default: state <= PLAY;
        endcase
      end
    end
  end

  // Lights are decoded from registers only; dark whenever a round is not in play.
  assign bus.lights      = (state == PLAY) ? (NUM_LIGHTS'(1) << pos) : '0;
  assign bus.win_left    = win_l;
  assign bus.win_right   = win_r;
  assign bus.left_score  = l_sc;
  assign bus.right_score = r_sc;
  assign bus.match_over  = over;
endmodule

// File: tb/tb_tug_of_war_field.sv
// Scoreboard bench for tug_of_war_field: the driver queues hand-computed expectations tagged
// with the cycle they apply to, and an independent monitor compares them when due.
module tb_tug_of_war_field;
  typedef struct packed {
    logic [8:0] lights;
    logic       wl;
    logic       wr;
    logic [2:0] ls;
    logic [2:0] rs;
    logic       mo;
  } exp_t;

  localparam logic [8:0] CTR = 9'b000010000;

  logic  clk;
  logic  rst_n;
  int    cyc   = 0;
  int    total = 0;
  int    pass  = 0;
  event  chk_ev;
  exp_t  exp_q[$];
  int    cyc_q[$];
  string name_q[$];
  exp_t  got, e;
  string nm;

  tug_of_war_field_if #(.NUM_LIGHTS(9), .SCORE_W(3)) bus ();

  tug_of_war_field #(
    .NUM_LIGHTS(9), .SCORE_W(3), .MATCH_POINTS(3), .HOLD_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [8:0] li, input logic wl, input logic wr,
                              input logic [2:0] ls, input logic [2:0] rs, input logic mo);
    exp_t x;
    x.lights = li; x.wl = wl; x.wr = wr; x.ls = ls; x.rs = rs; x.mo = mo;
    return x;
  endfunction

  task automatic push(input exp_t x, input int c, input string n);
    exp_q.push_back(x);
    cyc_q.push_back(c);
    name_q.push_back(n);
  endtask

  // Drive one cycle of inputs; the expectation applies after the next posedge.
  task automatic step(input logic l, input logic r, input logic rn, input logic rs,
                      input exp_t x, input string n);
    @(negedge clk);
    #1;
    rst_n = rn; bus.L = l; bus.R = r; bus.restart = rs;
    push(x, cyc + 1, n);
  endtask

  // Walk the light from centre to one end and past it, then ride out the hold.
  task automatic play_round(input logic left, input logic [2:0] ls0, input logic [2:0] rs0,
                            input logic fin, input logic abort);
    logic [2:0] ls1, rs1;
    logic [8:0] lt;
    ls1 = left ? ls0 + 3'd1 : ls0;
    rs1 = left ? rs0 : rs0 + 3'd1;
    for (int k = 1; k <= 4; k++) begin
      lt = left ? (CTR << k) : (CTR >> k);
      step(left, !left, 1'b1, 1'b0, mk(lt, 1'b0, 1'b0, ls0, rs0, 1'b0), "move");
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(lt, 1'b0, 1'b0, ls0, rs0, 1'b0), "move_rel");
    end
    step(left, !left, 1'b1, 1'b0, mk(9'd0, left, !left, ls1, rs1, fin), "round_win");
    if (abort) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(9'd0, left, !left, ls1, rs1, 1'b0), "hold1");
    end else if (!fin) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(9'd0, left, !left, ls1, rs1, 1'b0), "hold1");
      step(left, !left, 1'b1, 1'b0, mk(9'd0, left, !left, ls1, rs1, 1'b0), "hold2_press");
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(9'd0, left, !left, ls1, rs1, 1'b0), "hold3");
      step(1'b0, 1'b0, 1'b1, 1'b0, mk(CTR, 1'b0, 1'b0, ls1, rs1, 1'b0), "hold_exit");
    end
  endtask

  // Monitor: compare every expectation that has come due.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
        got.lights = bus.lights;
        got.wl     = bus.win_left;
        got.wr     = bus.win_right;
        got.ls     = bus.left_score;
        got.rs     = bus.right_score;
        got.mo     = bus.match_over;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        void'(cyc_q.pop_front());
        total++;
        if (got === e) pass++;
        else $display("FAIL %s @cyc %0d: got lights=%b wl=%b wr=%b ls=%0d rs=%0d mo=%b, want lights=%b wl=%b wr=%b ls=%0d rs=%0d mo=%b",
                      nm, cyc, got.lights, got.wl, got.wr, got.ls, got.rs, got.mo,
                      e.lights, e.wl, e.wr, e.ls, e.rs, e.mo);
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; bus.L = 1'b1; bus.R = 1'b1; bus.restart = 1'b0;

    // Keys held through reset never count as a press.
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "reset");
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "held_after_rst");
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "held2");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "release");

    // A held key moves the light exactly once.
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(9'b000100000, 0, 0, 0, 0, 0), "l_press");
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0, mk(9'b000100000, 0, 0, 0, 0, 0), "l_held");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(9'b000100000, 0, 0, 0, 0, 0), "l_rel");
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "r_press");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "r_rel");

    // Simultaneous presses cancel.
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "both");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "both_rel");

    // Rounds: left, right, left, left (match).
    play_round(1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    play_round(1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
    play_round(1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
    play_round(1'b1, 3'd2, 3'd1, 1'b1, 1'b0);

    // Match over: presses have no effect.
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(9'd0, 1, 0, 3, 1, 1), "over_l");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(9'd0, 1, 0, 3, 1, 1), "over_rel");
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(9'd0, 1, 0, 3, 1, 1), "over_r");
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(9'd0, 1, 0, 3, 1, 1), "over_both");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(9'd0, 1, 0, 3, 1, 1), "over_rel2");

    // Restart beats a press in the same cycle, and the held key does not count afterwards.
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(CTR, 0, 0, 0, 0, 0), "restart");
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "restart_held");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "restart_rel");

    // Right round win, then asynchronous reset mid-hold, checked before the next posedge.
    play_round(1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push(mk(CTR, 0, 0, 0, 0, 0), cyc, "async_rst");
    ->chk_ev;
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "rst_hold");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(CTR, 0, 0, 0, 0, 0), "rst_rel");

    repeat (3) @(negedge clk);
    #2;
    total++;
    if (cyc_q.size() == 0) pass++;
    else $display("FAIL drain: %0d expectations unchecked, want 0", cyc_q.size());

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
